// File: rtl/prog_loader.sv
// Command-memory loader: packs a 32-bit word stream (most-significant word first) into commands
// and writes them into processor command memory while the processor is held in reset.
// Optional running-XOR checksum of the accepted words is built when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader #(
    parameter int unsigned CMD_W  = 128,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   num_cmds,
    input  logic              abort,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              write_prog_enable,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [CMD_W-1:0]  cmd_data,
    output logic              proc_reset,
    output logic              done,
    output logic              error,
    output logic [WORD_W-1:0] checksum
);

    localparam int unsigned BEATS = CMD_W / WORD_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned IDX_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ADDR_W-1:0]  r_start_addr;
    logic [IDX_W-1:0]   r_num_cmds;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_word_cnt;
    logic [CMD_W-1:0]   r_asm;

    logic               w_start_acc;
    logic               w_abort_acc;
    logic               w_beat;
    logic               w_cmd_end;
    logic               w_final;
    logic [IDX_W-1:0]   w_idx_next;
    logic [CMD_W-1:0]   w_asm_next;

    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_abort_acc = abort && ((r_state == S_LOAD) || (r_state == S_FLUSH));
    assign w_beat      = (r_state == S_LOAD) && in_valid && in_ready && !abort;
    assign w_cmd_end   = w_beat && (r_word_cnt == CNT_W'(BEATS - 1));
    assign w_idx_next  = r_idx + IDX_W'(1);
    assign w_final     = w_cmd_end && (w_idx_next == r_num_cmds);
    assign w_asm_next  = CMD_W'({r_asm, in_data});

    // Next state; an empty load also passes through FLUSH so done lands two cycles after start
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (num_cmds == '0) ? S_FLUSH : S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_final) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: w_next = abort ? S_IDLE : S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_start_addr      <= '0;
            r_num_cmds        <= '0;
            r_idx             <= '0;
            r_word_cnt        <= '0;
            r_asm             <= '0;
            in_ready          <= 1'b0;
            write_prog_enable <= 1'b0;
            cmd_addr          <= '0;
            cmd_data          <= '0;
            proc_reset        <= 1'b1;
            done              <= 1'b0;
            error             <= 1'b0;
        end else begin
            r_state           <= w_next;
            in_ready          <= (w_next == S_LOAD);
            write_prog_enable <= w_cmd_end;
            done              <= (w_next == S_DONE);
            error             <= w_abort_acc;

            if (w_start_acc) begin
                r_start_addr <= start_addr;
                r_num_cmds   <= num_cmds;
                r_idx        <= '0;
                r_word_cnt   <= '0;
                proc_reset   <= 1'b1;
            end

            if (w_beat) begin
                r_asm      <= w_asm_next;
                r_word_cnt <= (r_word_cnt == CNT_W'(BEATS - 1)) ? '0 : r_word_cnt + CNT_W'(1);
            end

            if (w_cmd_end) begin
                cmd_data <= w_asm_next;
                cmd_addr <= r_start_addr + r_idx[ADDR_W-1:0];
                r_idx    <= w_idx_next;
            end

            if (w_next == S_DONE) begin
                proc_reset <= 1'b0;
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] r_checksum;

    // Running XOR of accepted words; no beats occur in DONE so the value stays frozen there
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_checksum <= '0;
        end else if (w_start_acc) begin
            r_checksum <= '0;
        end else if (w_beat) begin
            r_checksum <= r_checksum ^ in_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of load scenarios plus hand-written reset sequences.
module tb_prog_loader;

    logic         clk;
    logic         reset;
    logic         start;
    logic [7:0]   start_addr;
    logic [8:0]   num_cmds;
    logic         abort;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic         write_prog_enable;
    logic [7:0]   cmd_addr;
    logic [127:0] cmd_data;
    logic         proc_reset;
    logic         done;
    logic         error;
    logic [31:0]  checksum;

    prog_loader #(.CMD_W(128), .WORD_W(32), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .num_cmds(num_cmds), .abort(abort), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .write_prog_enable(write_prog_enable), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .proc_reset(proc_reset), .done(done), .error(error),
        .checksum(checksum)
    );

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam logic [31:0] EXP_CKS = 32'h0000000F;
`else
    localparam logic [31:0] EXP_CKS = 32'h00000000;
`endif

    typedef struct {
        logic [7:0] sa;
        logic [8:0] n;
        bit         gap;
        int         abort_after;
        int         wset;
        int         exp_writes;
        int         exp_spacing;
        int         exp_done;
        int         exp_err;
        logic       exp_preset;
        bit         chk_cks;
    } vec_t;

    vec_t vecs[6];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // observed-event log, cleared before each scenario
    int           nw;
    logic [7:0]   wr_addr[8];
    logic [127:0] wr_data[8];
    int           wr_cyc[8];
    int           n_done;
    int           n_err;
    int           done_cyc;
    logic         done_preset;
    logic [31:0]  done_cks;
    int           beat_cyc[16];
    int           start_cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (write_prog_enable && nw < 8) begin
            wr_addr[nw] = cmd_addr;
            wr_data[nw] = cmd_data;
            wr_cyc[nw]  = cyc;
            nw = nw + 1;
        end
        if (done) begin
            n_done      = n_done + 1;
            done_cyc    = cyc;
            done_preset = proc_reset;
            done_cks    = checksum;
        end
        if (error) n_err = n_err + 1;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] get_word(input int set, input int k);
        if (set == 1) return 32'(1 << k);
        case (k)
            0:  return 32'h00000018;  1:  return 32'h0000000C;
            2:  return 32'h00000000;  3:  return 32'h00000001;
            4:  return 32'h00000005;  5:  return 32'h00000010;
            6:  return 32'h00000020;  7:  return 32'h00000030;
            8:  return 32'h00000ADD;  9:  return 32'h00000001;
            10: return 32'h00000002;  default: return 32'h00000003;
        endcase
    endfunction

    function automatic logic [127:0] exp_cmd(input int set, input int i);
        if (set == 1) return 128'h00000001_00000002_00000004_00000008;
        case (i)
            0:       return 128'h00000018_0000000C_00000000_00000001;
            1:       return 128'h00000005_00000010_00000020_00000030;
            default: return 128'h00000ADD_00000001_00000002_00000003;
        endcase
    endfunction

    task automatic clear_log();
        nw = 0; n_done = 0; n_err = 0; done_cyc = -1;
        done_preset = 1'bx; done_cks = 'x;
        for (int i = 0; i < 16; i++) beat_cyc[i] = -1;
    endtask

    task automatic run_vec(input vec_t v);
        int  total;
        int  k;
        int  budget;
        bit  tog;
        bit  beat;
        int  ref_cyc;
        clear_log();
        total = 4 * int'(v.n);
        @(posedge clk); #1;
        start = 1'b1; start_addr = v.sa; num_cmds = v.n;
        @(posedge clk); #1;
        start_cyc = cyc;
        start = 1'b0;
        k = 0; budget = 0; tog = 1'b0;
        while (k < total && budget < 400) begin
            in_data = get_word(v.wset, k);
            if (v.abort_after >= 0 && k == v.abort_after) begin
                abort = 1'b1; in_valid = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0; in_valid = 1'b0;
                break;
            end
            in_valid = v.gap ? tog : 1'b1;
            beat = in_valid && in_ready;
            @(posedge clk); #1;
            if (beat) begin
                beat_cyc[k] = cyc;
                k = k + 1;
            end
            tog = ~tog;
            budget = budget + 1;
        end
        in_valid = 1'b0;
        if (v.abort_after < 0) chk("feed_words", 128'(k), 128'(total));
        repeat (6) @(posedge clk);
        #1;

        chk("write_count", 128'(nw), 128'(v.exp_writes));
        for (int i = 0; i < nw && i < v.exp_writes; i++) begin
            chk("write_addr", 128'(wr_addr[i]), 128'(8'(v.sa + 8'(i))));
            chk("write_data", wr_data[i], exp_cmd(v.wset, i));
            chk("write_cycle", 128'(wr_cyc[i]), 128'(beat_cyc[4*i+3]));
            if (i > 0) chk("write_spacing", 128'(wr_cyc[i] - wr_cyc[i-1]), 128'(v.exp_spacing));
        end
        chk("done_count", 128'(n_done), 128'(v.exp_done));
        chk("error_count", 128'(n_err), 128'(v.exp_err));
        chk("proc_reset_end", 128'(proc_reset), 128'(v.exp_preset));
        chk("in_ready_idle", 128'(in_ready), 128'(0));
        if (v.exp_done == 1 && n_done == 1) begin
            ref_cyc = (v.n == 0) ? start_cyc : beat_cyc[total-1];
            chk("done_latency", 128'(done_cyc - ref_cyc), 128'(1));
            chk("proc_reset_at_done", 128'(done_preset), 128'(0));
            if (v.chk_cks) chk("checksum_at_done", 128'(done_cks), 128'(EXP_CKS));
        end
    endtask

    initial begin
        vecs[0] = '{sa:8'd0,   n:9'd3, gap:1'b0, abort_after:-1, wset:0, exp_writes:3, exp_spacing:4, exp_done:1, exp_err:0, exp_preset:1'b0, chk_cks:1'b0};
        vecs[1] = '{sa:8'd0,   n:9'd3, gap:1'b1, abort_after:-1, wset:0, exp_writes:3, exp_spacing:8, exp_done:1, exp_err:0, exp_preset:1'b0, chk_cks:1'b0};
        vecs[2] = '{sa:8'd5,   n:9'd0, gap:1'b0, abort_after:-1, wset:0, exp_writes:0, exp_spacing:4, exp_done:1, exp_err:0, exp_preset:1'b0, chk_cks:1'b0};
        vecs[3] = '{sa:8'd255, n:9'd2, gap:1'b0, abort_after:-1, wset:0, exp_writes:2, exp_spacing:4, exp_done:1, exp_err:0, exp_preset:1'b0, chk_cks:1'b0};
        vecs[4] = '{sa:8'd16,  n:9'd2, gap:1'b0, abort_after:6,  wset:0, exp_writes:1, exp_spacing:4, exp_done:0, exp_err:1, exp_preset:1'b1, chk_cks:1'b0};
        vecs[5] = '{sa:8'd7,   n:9'd1, gap:1'b0, abort_after:-1, wset:1, exp_writes:1, exp_spacing:4, exp_done:1, exp_err:0, exp_preset:1'b0, chk_cks:1'b1};

        reset = 1'b1; start = 1'b0; start_addr = '0; num_cmds = '0;
        abort = 1'b0; in_data = '0; in_valid = 1'b0;
        clear_log();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_proc_reset", 128'(proc_reset), 128'(1));
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_wpe", 128'(write_prog_enable), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_error", 128'(error), 128'(0));
        chk("rst_cmd_addr", 128'(cmd_addr), 128'(0));
        chk("rst_cmd_data", cmd_data, 128'(0));
        chk("rst_checksum", 128'(checksum), 128'(0));

        for (int v = 0; v < 6; v++) run_vec(vecs[v]);

        // reset right after the final beat must kill the pending strobe
        clear_log();
        @(posedge clk); #1;
        start = 1'b1; start_addr = 8'd3; num_cmds = 9'd1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_data = get_word(0, k); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_wpe", 128'(write_prog_enable), 128'(0));
        chk("midrst_cmd_data", cmd_data, 128'(0));
        chk("midrst_proc_reset", 128'(proc_reset), 128'(1));
        @(posedge clk); #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_write", 128'(nw), 128'(0));
        chk("midrst_no_done", 128'(n_done), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
